// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: pipeline slot, predictor update entry
// and the sequential PC increment.
package branch_resolver_pkg;

  // Struct width; the top-level XLEN parameter must match this value.
  localparam int PKG_XLEN = 32;

  localparam logic [PKG_XLEN-1:0] PC_STEP = PKG_XLEN'(4);

  typedef struct packed {
    logic                v;
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] pred_next_pc;
  } slot_t;

  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic                taken;
    logic [PKG_XLEN-1:0] target;
  } upd_t;

endpackage

// File: rtl/resolver_upd_fifo.sv
// Small synchronous FIFO buffering resolved-branch updates toward the predictor.
// DEPTH must be a power of two so the pointers wrap naturally.
module resolver_upd_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  upd_t push_data_i,
  output logic full_o,
  output logic valid_o,
  input  logic ready_i,
  output upd_t data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  upd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop;
  logic             wr_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign wr_en   = push_i & (~full_o | pop);
  // Head is forced to zero when empty so stale entries never leak out.
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolution: flush/redirect on misprediction plus a buffered
// predictor update stream. Define BRANCH_STATS_EN to build the stat counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN      = PKG_XLEN,
  parameter int UPD_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pred_next_pc,
  input  logic            stall,
  input  logic            ex_is_cond,
  input  logic            ex_is_jump,
  input  logic            ex_bcond,
  input  logic [XLEN-1:0] ex_target,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic            stall_req,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic [XLEN-1:0] upd_target,
  output logic [31:0]     stat_ctrl,
  output logic [31:0]     stat_miss
);

  slot_t           id_q, id_d;
  slot_t           ex_q, ex_d;
  logic            advance;
  logic            resolve;
  logic            taken;
  logic            miss;
  logic            push;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] correct_pc;
  upd_t            push_data;
  upd_t            head;

  assign advance    = ~stall & ~stall_req;
  assign resolve    = advance & ex_q.v;
  assign taken      = ex_is_jump | (ex_is_cond & ex_bcond);
  assign seq_pc     = ex_q.pc + PC_STEP;
  assign correct_pc = taken ? ex_target : seq_pc;
  assign miss       = resolve & (correct_pc != ex_q.pred_next_pc);
  assign push       = resolve & (ex_is_cond | ex_is_jump);

  assign flush       = miss;
  assign redirect_pc = miss ? correct_pc : seq_pc;

  always_comb begin
    id_d = id_q;
    ex_d = ex_q;
    if (advance) begin
      ex_d = id_q;
      id_d = '{v: if_valid, pc: if_pc, pred_next_pc: if_pred_next_pc};
      // A miss squashes both slots, dropping the wrong-path IF instruction too.
      if (miss) begin
        ex_d.v = 1'b0;
        id_d.v = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q <= '0;
      ex_q <= '0;
    end else begin
      id_q <= id_d;
      ex_q <= ex_d;
    end
  end

  assign push_data = '{pc: ex_q.pc, taken: taken, target: correct_pc};

  resolver_upd_fifo #(
    .DEPTH(UPD_DEPTH)
  ) u_upd_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .full_o      (stall_req),
    .valid_o     (upd_valid),
    .ready_i     (upd_ready),
    .data_o      (head)
  );

  assign upd_pc     = head.pc;
  assign upd_taken  = head.taken;
  assign upd_target = head.target;

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_ctrl_q;
  logic [31:0] stat_miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ctrl_q <= '0;
      stat_miss_q <= '0;
    end else begin
      if (push && stat_ctrl_q != '1) stat_ctrl_q <= stat_ctrl_q + 32'd1;
      if (miss && stat_miss_q != '1) stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign stat_ctrl = stat_ctrl_q;
  assign stat_miss = stat_miss_q;
`else
  assign stat_ctrl = '0;
  assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver; inputs change 1 ns after
// the rising edge and outputs are sampled 2 ns later.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pred_next_pc;
  logic        stall;
  logic        ex_is_cond;
  logic        ex_is_jump;
  logic        ex_bcond;
  logic [31:0] ex_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        stall_req;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] stat_ctrl;
  logic [31:0] stat_miss;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_ctrl = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  branch_resolver #(.XLEN(32), .UPD_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_next_pc(if_pred_next_pc), .stall(stall), .ex_is_cond(ex_is_cond),
    .ex_is_jump(ex_is_jump), .ex_bcond(ex_bcond), .ex_target(ex_target),
    .flush(flush), .redirect_pc(redirect_pc), .stall_req(stall_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .stat_ctrl(stat_ctrl), .stat_miss(stat_miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_ex();
    ex_is_cond = 0; ex_is_jump = 0; ex_bcond = 0; ex_target = 32'h0;
  endtask

  task automatic test_reset();
    reset = 0; if_valid = 0; if_pc = 0; if_pred_next_pc = 0; stall = 0;
    upd_ready = 1; clear_ex();
    #3;
    total_cnt++; if (flush !== 1'b0) $display("FAIL reset_flush got=%b exp=0", flush); else pass_cnt++;
    total_cnt++; if (stall_req !== 1'b0) $display("FAIL reset_stall_req got=%b exp=0", stall_req); else pass_cnt++;
    total_cnt++; if (upd_valid !== 1'b0) $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); else pass_cnt++;
    total_cnt++; if ({upd_pc, upd_taken, upd_target} !== 65'h0)
      $display("FAIL reset_upd_fields got=%h/%b/%h exp=0", upd_pc, upd_taken, upd_target); else pass_cnt++;
    total_cnt++; if ({stat_ctrl, stat_miss} !== 64'h0)
      $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_ctrl, stat_miss); else pass_cnt++;
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic test_not_taken();
    if_valid = 1; if_pc = 32'h100; if_pred_next_pc = 32'h104;
    tick();
    if_valid = 0;
    settle();
    total_cnt++; if (flush !== 1'b0) $display("FAIL nt_flush_id got=%b exp=0", flush); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (flush !== 1'b0) $display("FAIL nt_flush_ex got=%b exp=0", flush); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h104) $display("FAIL nt_redirect got=%h exp=104", redirect_pc); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (upd_valid !== 1'b0) $display("FAIL nt_no_upd got=%b exp=0", upd_valid); else pass_cnt++;
  endtask

  task automatic test_taken_miss();
    if_valid = 1; if_pc = 32'h200; if_pred_next_pc = 32'h204;
    tick();
    if_pc = 32'h204; if_pred_next_pc = 32'h208;
    tick();
    if_pc = 32'h208; if_pred_next_pc = 32'h20c;
    ex_is_cond = 1; ex_bcond = 1; ex_target = 32'h180;
    settle();
    total_cnt++; if (flush !== 1'b1) $display("FAIL tm_flush got=%b exp=1", flush); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h180) $display("FAIL tm_redirect got=%h exp=180", redirect_pc); else pass_cnt++;
    exp_ctrl++; exp_miss++;
    tick();
    // A still-valid EX slot would mismatch this jump target and flush.
    if_valid = 0; clear_ex(); ex_is_jump = 1; ex_target = 32'h999;
    settle();
    total_cnt++; if (flush !== 1'b0) $display("FAIL tm_ex_squashed got=%b exp=0", flush); else pass_cnt++;
    total_cnt++; if (upd_valid !== 1'b1) $display("FAIL tm_upd_valid got=%b exp=1", upd_valid); else pass_cnt++;
    total_cnt++; if ({upd_pc, upd_taken, upd_target} !== {32'h200, 1'b1, 32'h180})
      $display("FAIL tm_upd_entry got=%h/%b/%h exp=200/1/180", upd_pc, upd_taken, upd_target); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (flush !== 1'b0) $display("FAIL tm_id_squashed got=%b exp=0", flush); else pass_cnt++;
    total_cnt++; if (upd_valid !== 1'b0) $display("FAIL tm_single_push got=%b exp=0", upd_valid); else pass_cnt++;
    clear_ex();
  endtask

  task automatic test_alias();
    if_valid = 1; if_pc = 32'h300; if_pred_next_pc = 32'h400;
    tick();
    if_valid = 0;
    tick();
    settle();
    total_cnt++; if (flush !== 1'b1) $display("FAIL al_flush got=%b exp=1", flush); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h304) $display("FAIL al_redirect got=%h exp=304", redirect_pc); else pass_cnt++;
    exp_miss++;
    tick();
    settle();
    total_cnt++; if (upd_valid !== 1'b0) $display("FAIL al_no_push got=%b exp=0", upd_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    upd_ready = 0;
    if_valid = 1; if_pc = 32'h500; if_pred_next_pc = 32'h600;
    tick();
    if_pc = 32'h600; if_pred_next_pc = 32'h700;
    tick();
    if_pc = 32'h700; if_pred_next_pc = 32'h800;
    ex_is_jump = 1; ex_target = 32'h600;
    settle();
    total_cnt++; if ({flush, stall_req} !== 2'b00) $display("FAIL bp_j1 got=%b%b exp=00", flush, stall_req); else pass_cnt++;
    tick();
    if_valid = 0; ex_target = 32'h700;
    settle();
    total_cnt++; if ({flush, stall_req, upd_valid} !== 3'b001)
      $display("FAIL bp_j2 got=%b%b%b exp=001", flush, stall_req, upd_valid); else pass_cnt++;
    tick();
    // J3 sits in EX; a wrong target proves it is not resolved while full.
    ex_target = 32'h123;
    settle();
    total_cnt++; if (stall_req !== 1'b1) $display("FAIL bp_full got=%b exp=1", stall_req); else pass_cnt++;
    total_cnt++; if (flush !== 1'b0) $display("FAIL bp_no_resolve got=%b exp=0", flush); else pass_cnt++;
    tick();
    upd_ready = 1; ex_target = 32'h800;
    settle();
    total_cnt++; if ({stall_req, upd_pc} !== {1'b1, 32'h500})
      $display("FAIL bp_hold got=%b/%h exp=1/500", stall_req, upd_pc); else pass_cnt++;
    tick();
    upd_ready = 0;
    settle();
    total_cnt++; if ({stall_req, flush, upd_pc} !== {1'b0, 1'b0, 32'h600})
      $display("FAIL bp_after_pop got=%b/%b/%h exp=0/0/600", stall_req, flush, upd_pc); else pass_cnt++;
    tick();
    clear_ex();
    settle();
    total_cnt++; if ({stall_req, upd_pc} !== {1'b1, 32'h600})
      $display("FAIL bp_j3_pushed got=%b/%h exp=1/600", stall_req, upd_pc); else pass_cnt++;
    upd_ready = 1;
    tick();
    settle();
    total_cnt++; if ({upd_valid, upd_pc, upd_taken, upd_target} !== {1'b1, 32'h700, 1'b1, 32'h800})
      $display("FAIL bp_j3_entry got=%b/%h/%b/%h exp=1/700/1/800", upd_valid, upd_pc, upd_taken, upd_target); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (upd_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", upd_valid); else pass_cnt++;
    exp_ctrl += 3;
  endtask

  task automatic test_stall_hold();
    if_valid = 1; if_pc = 32'h900; if_pred_next_pc = 32'h904;
    tick();
    if_valid = 0;
    tick();
    stall = 1; ex_is_cond = 1; ex_bcond = 1; ex_target = 32'hA00;
    for (int i = 0; i < 3; i++) begin
      settle();
      total_cnt++; if (flush !== 1'b0) $display("FAIL sh_stalled_flush cyc=%0d got=%b exp=0", i, flush); else pass_cnt++;
      tick();
    end
    stall = 0;
    settle();
    total_cnt++; if ({flush, redirect_pc} !== {1'b1, 32'hA00})
      $display("FAIL sh_flush got=%b/%h exp=1/a00", flush, redirect_pc); else pass_cnt++;
    exp_ctrl++; exp_miss++;
    tick();
    settle();
    total_cnt++; if ({flush, upd_valid, upd_pc} !== {1'b0, 1'b1, 32'h900})
      $display("FAIL sh_one_pulse got=%b/%b/%h exp=0/1/900", flush, upd_valid, upd_pc); else pass_cnt++;
    tick();
    settle();
    total_cnt++; if (upd_valid !== 1'b0) $display("FAIL sh_one_push got=%b exp=0", upd_valid); else pass_cnt++;
    clear_ex();
  endtask

  task automatic test_stats();
`ifdef BRANCH_STATS_EN
    total_cnt++; if (stat_ctrl !== 32'(exp_ctrl)) $display("FAIL stat_ctrl got=%0d exp=%0d", stat_ctrl, exp_ctrl); else pass_cnt++;
    total_cnt++; if (stat_miss !== 32'(exp_miss)) $display("FAIL stat_miss got=%0d exp=%0d", stat_miss, exp_miss); else pass_cnt++;
`else
    total_cnt++; if ({stat_ctrl, stat_miss} !== 64'h0) $display("FAIL stat_tied got=%0d/%0d exp=0/0", stat_ctrl, stat_miss); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    upd_ready = 0;
    if_valid = 1; if_pc = 32'hB00; if_pred_next_pc = 32'hB04;
    tick();
    if_pc = 32'hB04; if_pred_next_pc = 32'hB08;
    tick();
    if_valid = 0; ex_is_jump = 1; ex_target = 32'hB04;
    tick();
    ex_target = 32'hB08;
    tick();
    clear_ex();
    settle();
    total_cnt++; if ({stall_req, upd_valid} !== 2'b11) $display("FAIL rm_pending got=%b%b exp=11", stall_req, upd_valid); else pass_cnt++;
    reset = 0;
    #1;
    total_cnt++; if ({upd_valid, stall_req} !== 2'b00) $display("FAIL rm_fifo_clear got=%b%b exp=00", upd_valid, stall_req); else pass_cnt++;
    total_cnt++; if ({stat_ctrl, stat_miss, upd_pc} !== 96'h0)
      $display("FAIL rm_zeroed got=%0d/%0d/%h exp=0/0/0", stat_ctrl, stat_miss, upd_pc); else pass_cnt++;
    tick();
    reset = 1; upd_ready = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_not_taken();
    test_taken_miss();
    test_alias();
    test_backpressure();
    test_stall_hold();
    test_stats();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

EX-stage branch resolution unit: the consumer side of the IF-stage GShare prediction path. It carries each fetched instruction's predicted next PC through the ID and EX slots. At EX it compares that prediction with the actual outcome, then drives the pipeline flush and PC redirect. It also produces a buffered update stream back to the predictor's BTB/PHT/BHSR.

## Interface
Parameters:
- XLEN, 32, PC/target width
- UPD_DEPTH, 2, update FIFO entries (power of 2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (0 = reset)
- if_valid  input  1  IF holds a real instruction
- if_pc  input  XLEN  PC of the IF instruction
- if_pred_next_pc  input  XLEN  next PC chosen by the predictor
- stall  input  1  pipeline hazard stall; freezes the ID and EX slots
- ex_is_cond  input  1  EX instruction is a conditional branch
- ex_is_jump  input  1  EX instruction is jal/jalr
- ex_bcond  input  1  branch condition result
- ex_target  input  XLEN  computed branch/jump target
- flush  output  1  squash IF/ID and ID/EX (combinational)
- redirect_pc  output  XLEN  correct next PC, valid when flush=1
- stall_req  output  1  update FIFO full; pipeline must stall
- upd_valid  output  1  update entry available
- upd_ready  input  1  predictor accepts update
- upd_pc  output  XLEN  PC of the resolved control instruction
- upd_taken  output  1  actual direction
- upd_target  output  XLEN  actual next PC
- stat_ctrl  output  32  resolved control-instruction count
- stat_miss  output  32  misprediction count

## Operation
- Slot = {v, pc, pred_next_pc}. There are two slots: ID and EX.
- Advance when stall=0 and stall_req=0:
  - EX ← ID.
  - ID ← {if_valid, if_pc, if_pred_next_pc}.
- Resolve happens only on an advance cycle with EX.v=1. Nothing resolves while frozen, so each instruction resolves exactly once.
- Direction and correct next PC:
  - taken = ex_is_jump | (ex_is_cond & ex_bcond)
  - correct = taken ? ex_target : pc+4, with wrap-around modulo 2^XLEN
- miss = resolve & (correct != pred_next_pc). Non-control instructions also mispredict when a BTB alias predicted a target other than pc+4.
- On miss:
  - flush=1 and redirect_pc=correct.
  - At the edge, ID.v←0 and EX.v←0, so the incoming IF instruction is dropped.
- Push to the update FIFO on resolve & (ex_is_cond | ex_is_jump), carrying {pc, taken, correct}. Non-control aliases flush but are not pushed.
- FIFO pop on upd_valid & upd_ready. A simultaneous push and pop when full is legal: occupancy is unchanged.
- stall_req = FIFO full. It suppresses advance and resolve.
- Outputs when not active:
  - flush=0 whenever resolve=0.
  - redirect_pc = EX.pc+4 when flush=0 (don't-care for consumers).

## Timing
- flush and redirect_pc are combinational in the resolving cycle. The PC register loads redirect_pc at the same edge.
- upd_valid rises 1 cycle after the push edge, then holds until the handshake completes.
- Reset values: all slot v=0, FIFO empty, flush=0, stall_req=0, upd_valid=0, upd_* = 0, stat_* = 0.
- Asserting reset mid-operation discards all pending updates immediately.

## Configuration
- BRANCH_STATS_EN defined:
  - stat_ctrl increments on each push.
  - stat_miss increments on each miss, including non-control aliases.
  - Both counters saturate at 0xFFFF_FFFF.
- BRANCH_STATS_EN undefined: counters are not built and stat_ctrl/stat_miss are tied to 0.

## Structure
- branch_resolver_pkg holds:
  - the slot struct and the update-entry struct {pc, taken, target}
  - the PC_STEP = 4 constant
- One sub-module, resolver_upd_fifo: a UPD_DEPTH-entry synchronous FIFO with valid/ready output, full flag and the same async active-low reset.

## Test plan
- Correct not-taken:
  - Stimulus: IF pc=0x100, pred 0x104, not a branch; 2 advances.
  - Required: flush=0 throughout, no upd_valid.
- Taken mispredict:
  - Stimulus: pc=0x200, pred 0x204, ex_is_cond=1, bcond=1, target=0x180.
  - Required: flush=1 and redirect_pc=0x180 in the resolve cycle; the next cycle has ID.v=EX.v=0; upd {0x200, 1, 0x180} appears 1 cycle later.
- Alias miss:
  - Stimulus: non-control pc=0x300, pred 0x400.
  - Required: flush=1, redirect_pc=0x304, no update pushed, stat_miss +1 with the macro defined.
- Backpressure:
  - Stimulus: upd_ready=0, three back-to-back correctly predicted jumps.
  - Required: stall_req=1 after the 2nd push and the third jump is not resolved. Raising upd_ready pops 1 entry and the third jump resolves on the following advance.
- Stall hold:
  - Stimulus: stall=1 for 3 cycles with a mispredicting branch in EX.
  - Required: flush=0 during the stall; a single flush pulse and a single push once stall drops.
- Reset mid-operation:
  - Stimulus: reset=0 with 2 FIFO entries pending.
  - Required: upd_valid=0, stall_req=0 and stat_*=0 immediately, without waiting for a clock edge.
